apf_clock_ctrl: RTL
===================

# apf_clock_ctrl

Clock-enable and reset sequencer sitting directly downstream of the system PLL. It consumes the 3.579545 MHz PLL output clock and the PLL lock indication. It produces the core reset and the CPU phase clock enables, plus a pause gate that only acts on CPU-cycle boundaries. All APF core logic runs on `clk_sys` and is qualified by these enables.

## Interface

Parameters:
- `CE_DIV`, 4: `clk_sys` cycles per CPU cycle. Even, ≥2; default gives 894.886 kHz.
- `RST_HOLD`, 64: `clk_sys` cycles core reset is held after lock or reset request. ≥1.

Ports:
- `clk_sys` in 1: PLL `outclk_0`, 3.579545 MHz. Sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `pll_locked` in 1: PLL `locked`, asynchronous to `clk_sys`.
- `reset_req` in 1: user/HPS core reset request, synchronous, level or pulse.
- `pause_req` in 1: synchronous pause request, level.
- `core_reset` out 1: active-high reset to the core.
- `cpu_ce_p` out 1: one-cycle enable at CPU phase 0.
- `cpu_ce_n` out 1: one-cycle enable at CPU phase `CE_DIV/2`.
- `paused` out 1: CPU enables currently suppressed.
- `locked_sync` out 1: `pll_locked` after 2-FF synchronizer.

## Operation

- **Synchronizer:** 2-FF chain on `pll_locked`. The second flop is `locked_sync`. Nothing else samples `pll_locked`.
- **FSM states:**
  - WAIT_LOCK
    - `core_reset`=1; hold counter, phase counter and `paused` cleared.
    - Exit to HOLD when `locked_sync`=1.
  - HOLD
    - `core_reset`=1; hold counter increments each cycle from 0.
    - `locked_sync`=0 → WAIT_LOCK.
    - Otherwise, `reset_req`=1 → stay in HOLD, counter cleared to 0.
    - Otherwise, counter==`RST_HOLD`-1 → RUN.
  - RUN
    - `core_reset`=0; phase counter runs 0..`CE_DIV`-1 and wraps.
    - `locked_sync`=0 → WAIT_LOCK.
    - Otherwise, `reset_req`=1 → HOLD with counter 0.
- **Priority:** lock loss > `reset_req` > normal progress.
- **Phase counter:** forced to 0 on every entry to RUN. Width is clog2(`CE_DIV`).
- **Enables:**
  - `cpu_ce_p` = RUN & phase==0 & !`paused`.
  - `cpu_ce_n` = RUN & phase==`CE_DIV`/2 & !`paused`.
  - Decoded only from registered state. No combinational path from any input port to any output.
- **Pause:**
  - `paused` loads `pause_req` only on the edge where phase goes `CE_DIV`-1 → 0. It is held otherwise.
  - Result: enables are always emitted as complete p/n pairs, never a lone `cpu_ce_p`.
  - The phase counter keeps running while paused.
- **Hold counter:** width clog2(`RST_HOLD`+1). Saturates; never wraps.

## Timing

- **Reset values** (while `rst_n`=0, applied at the next edge):
  - state WAIT_LOCK, both sync flops 0, counters 0.
  - `core_reset`=1, `cpu_ce_p`=0, `cpu_ce_n`=0, `paused`=0, `locked_sync`=0.
- **Lock latency:** `pll_locked` rising → `locked_sync` high 2 edges later → HOLD on the 3rd edge.
- **Release:** `core_reset` falls `RST_HOLD` edges after entering HOLD. With `pll_locked` high and `rst_n` released at edge 0, `core_reset` falls at edge 3+`RST_HOLD` (67 by default).
- **First enable:** first `cpu_ce_p` is in the same cycle `core_reset` is first 0. First `cpu_ce_n` follows `CE_DIV`/2 cycles later.
- **`reset_req` in RUN:** `core_reset`=1 and enables 0 from the next edge.
- **Lock loss:** `pll_locked` low → `core_reset` high 3 edges later (2 sync + 1 transition). Glitches shorter than one `clk_sys` period may be missed; this is acceptable.
- **Pause latency:** between 1 and `CE_DIV` cycles to the next phase-0 edge. Release latency is the same.
- **`rst_n` mid-operation:** overrides everything at the next edge, regardless of state.

## Test plan

1. **Power-up:** `rst_n`=0 for 3 cycles, `pll_locked`=1 throughout, release at edge 0 → `locked_sync` high at edge 2, `core_reset` falls at edge 67, `cpu_ce_p` high in that same cycle.
2. **Divider, RUN, no pause:** `cpu_ce_p` high on cycles 0, 4, 8, …; `cpu_ce_n` high on cycles 2, 6, 10, … (relative to RUN entry). Never both high together; exactly 1 cycle wide.
3. **`reset_req` one-cycle pulse in RUN:** `core_reset`=1 from the next edge for exactly 64 cycles. No enables during that time. Phase restarts at 0.
4. **Lock loss:** `pll_locked` low for 5 cycles in RUN → `core_reset` high 3 edges after the drop. After relock, `core_reset` low again 3+64 edges after `pll_locked` rises.
5. **Pause:** `pause_req` raised when phase==1 → the `cpu_ce_n` at phase 2 still fires, then no enables from the next phase 0. `pause_req` dropped at phase 3 → `cpu_ce_p` resumes at the immediately following phase 0.
6. **`reset_req` with simultaneous lock loss in HOLD:** state goes to WAIT_LOCK, not HOLD. `rst_n` pulled low mid-RUN → all outputs at reset values after one edge.

Source files
------------

// File: rtl/apf_clock_ctrl.sv
// Core reset sequencer and CPU phase-enable generator downstream of the system PLL.
// Every output is a flop; enables are decoded from next-state so they align with core_reset.
module apf_clock_ctrl #(
  parameter int CE_DIV   = 4,
  parameter int RST_HOLD = 64
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic reset_req,
  input  logic pause_req,
  output logic core_reset,
  output logic cpu_ce_p,
  output logic cpu_ce_n,
  output logic paused,
  output logic locked_sync
);

  localparam int PW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(CE_DIV - 1);
  localparam logic [PW-1:0] PH_HALF   = PW'(CE_DIV / 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  state_t        state;
  logic          lock_meta;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] phase;

  logic          ph_wrap;
  logic [PW-1:0] phase_nxt;
  logic          paused_nxt;

  // Pause is only sampled on the wrap into phase 0 so p/n enables stay paired.
  assign ph_wrap    = (phase == PH_LAST);
  assign phase_nxt  = ph_wrap ? '0 : phase + PW'(1);
  assign paused_nxt = ph_wrap ? pause_req : paused;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      lock_meta   <= 1'b0;
      locked_sync <= 1'b0;
      hold_cnt    <= '0;
      phase       <= '0;
      paused      <= 1'b0;
      core_reset  <= 1'b1;
      cpu_ce_p    <= 1'b0;
      cpu_ce_n    <= 1'b0;
    end else begin
      lock_meta   <= pll_locked;
      locked_sync <= lock_meta;
      core_reset  <= 1'b1;
      cpu_ce_p    <= 1'b0;
      cpu_ce_n    <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          hold_cnt <= '0;
          phase    <= '0;
          paused   <= 1'b0;
          if (locked_sync) state <= HOLD;
        end
        HOLD: begin
          if (!locked_sync) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            phase    <= '0;
            paused   <= 1'b0;
          end else if (reset_req) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            hold_cnt   <= '0;
            phase      <= '0;
            core_reset <= 1'b0;
            cpu_ce_p   <= !paused;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          if (!locked_sync) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            phase    <= '0;
            paused   <= 1'b0;
          end else if (reset_req) begin
            state    <= HOLD;
            hold_cnt <= '0;
            phase    <= '0;
          end else begin
            phase      <= phase_nxt;
            paused     <= paused_nxt;
            core_reset <= 1'b0;
            cpu_ce_p   <= ph_wrap & !paused_nxt;
            cpu_ce_n   <= (phase_nxt == PH_HALF) & !paused_nxt;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          hold_cnt <= '0;
          phase    <= '0;
          paused   <= 1'b0;
        end
      endcase
    end
  end

endmodule
